laplace_kernel_pipe: RTL and testbench

//  2-stage pipelined 4-neighbour Laplacian kernel: out = 4*C - (N+S+E+W) per pixel.

---
 rtl/laplace_pkg.sv | 11 +
 rtl/full_adder.sv | 16 +
 rtl/ripple_adder.sv | 28 ++
 rtl/laplace_kernel_pipe.sv | 165 ++++++++++++++++
 tb/tb_laplace_kernel_pipe.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/laplace_pkg.sv
// Shared constants and types for the Laplacian kernel pipeline.
package laplace_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned OUT_W_DEF = PIX_W_DEF + 3;
  localparam int unsigned PIX_MAX   = (1 << PIX_W_DEF) - 1;

  typedef logic        [PIX_W_DEF-1:0] pix_t;
  typedef logic signed [OUT_W_DEF-1:0] res_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used to build every ripple adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  // Sum and carry of three input bits
  always_comb begin
    s_o  = a_i ^ b_i ^ ci_i;
    co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
  end

endmodule

// File: rtl/ripple_adder.sv
// W-bit ripple-carry adder: {cout_o, sum_o} = a_i + b_i + cin_i.
module ripple_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry;

  assign carry[0] = cin_i;
  assign cout_o   = carry[W];

  // Carry chain of full-adder cells, LSB first
  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (carry[i]),
      .s_o  (sum_o[i]),
      .co_o (carry[i+1])
    );
  end

endmodule

// File: rtl/laplace_kernel_pipe.sv
// Two-stage 4-neighbour Laplacian: out = 4*C - (N+S+E+W), valid/ready on both sides.
// Optional clamp to 0..2^PIX_W-1 when LAPLACE_SAT_EN is defined.
module laplace_kernel_pipe
  import laplace_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF,
  parameter int unsigned OUT_W = PIX_W + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_c,
  input  logic [PIX_W-1:0] in_n,
  input  logic [PIX_W-1:0] in_s,
  input  logic [PIX_W-1:0] in_e,
  input  logic [PIX_W-1:0] in_w,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_pix,
  output logic             out_last
);

  localparam int unsigned NS_W  = PIX_W + 1;
  localparam int unsigned C4_W  = PIX_W + 2;
  localparam int unsigned RES_W = PIX_W + 3;

  // Stage 1 state
  logic            s1_valid_q;
  logic            s1_last_q;
  logic [NS_W-1:0] ns_q, ew_q;
  logic [C4_W-1:0] c4_q;

  // Stage 2 state
  logic             s2_valid_q;
  logic             out_last_q;
  logic [OUT_W-1:0] out_pix_q;

  // Next-state values
  logic [NS_W-1:0]  ns_d, ew_d;
  logic [C4_W-1:0]  c4_d;
  logic [OUT_W-1:0] out_pix_d;

  logic adv1, adv2;

  // Pipeline advance: a stage moves when it is empty or the next one moves
  assign adv2      = !s2_valid_q || out_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;
  assign out_pix   = out_pix_q;
  assign out_last  = out_last_q;

  // Stage 1 arithmetic: vertical and horizontal neighbour pairs
  logic [PIX_W-1:0] ns_sum, ew_sum;
  logic             ns_co, ew_co;

  ripple_adder #(.W(PIX_W)) u_ns (
    .a_i    (in_n),
    .b_i    (in_s),
    .cin_i  (1'b0),
    .sum_o  (ns_sum),
    .cout_o (ns_co)
  );

  ripple_adder #(.W(PIX_W)) u_ew (
    .a_i    (in_e),
    .b_i    (in_w),
    .cin_i  (1'b0),
    .sum_o  (ew_sum),
    .cout_o (ew_co)
  );

  assign ns_d = {ns_co, ns_sum};
  assign ew_d = {ew_co, ew_sum};
  assign c4_d = {in_c, 2'b00};

  // Stage 2 arithmetic: total neighbour sum, then c4 + ~nbr + 1
  logic [NS_W-1:0] nbr_sum;
  logic            nbr_co;
  logic [C4_W-1:0] nbr;
  logic [C4_W-1:0] sub_sum;
  logic            sub_co;

  ripple_adder #(.W(NS_W)) u_nbr (
    .a_i    (ns_q),
    .b_i    (ew_q),
    .cin_i  (1'b0),
    .sum_o  (nbr_sum),
    .cout_o (nbr_co)
  );

  assign nbr = {nbr_co, nbr_sum};

  ripple_adder #(.W(C4_W)) u_sub (
    .a_i    (c4_q),
    .b_i    (~nbr),
    .cin_i  (1'b1),
    .sum_o  (sub_sum),
    .cout_o (sub_co)
  );

`ifdef LAPLACE_SAT_EN
  localparam logic [C4_W-1:0] PIX_MAX_L = C4_W'((1 << PIX_W) - 1);

  logic [PIX_W-1:0] sat_val;

  // Clamp: a missing carry out of the subtract means the result is negative
  always_comb begin
    sat_val = sub_sum[PIX_W-1:0];
    if (!sub_co) begin
      sat_val = '0;
    end else if (sub_sum > PIX_MAX_L) begin
      sat_val = PIX_MAX_L[PIX_W-1:0];
    end
    out_pix_d = OUT_W'(sat_val);
  end
`else
  logic [RES_W-1:0] res;

  // Borrow-free subtract: carry out set means c4 >= nbr, so the sign is its inverse
  assign res = {~sub_co, sub_sum};

  // Raw signed result, sign-extended to the output width
  always_comb begin
    out_pix_d = OUT_W'($signed(res));
  end
`endif

  // Stage 1 registers: load on advance, data only with a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      ns_q       <= '0;
      ew_q       <= '0;
      c4_q       <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_last_q <= in_last;
        ns_q      <= ns_d;
        ew_q      <= ew_d;
        c4_q      <= c4_d;
      end
    end
  end

  // Stage 2 registers: result held stable while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_pix_q  <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_last_q <= s1_last_q;
        out_pix_q  <= out_pix_d;
      end
    end
  end

endmodule

// File: tb/tb_laplace_kernel_pipe.sv
// Self-checking bench for laplace_kernel_pipe; honours LAPLACE_SAT_EN in its model.
module tb_laplace_kernel_pipe;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned OUT_W = 11;

  typedef struct packed {
    logic [OUT_W-1:0] pix;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_c, in_n, in_s, in_e, in_w;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_pix;
  logic             out_last;

  int   tests  = 0;
  int   failed = 0;
  int   n_out  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  laplace_kernel_pipe #(.PIX_W(PIX_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .in_n      (in_n),
    .in_s      (in_s),
    .in_e      (in_e),
    .in_w      (in_w),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_last  (out_last)
  );

  // Reference result for one beat
  function automatic exp_t model(input logic [PIX_W-1:0] c, n, s, e, w, input logic last);
    int   d;
    exp_t r;
    d = 4 * int'(c) - (int'(n) + int'(s) + int'(e) + int'(w));
`ifdef LAPLACE_SAT_EN
    if (d < 0) d = 0;
    if (d > 255) d = 255;
`endif
    r.pix  = OUT_W'(d);
    r.last = last;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [PIX_W-1:0] c, n, s, e, w, input logic last);
    in_valid = v;
    in_c = c; in_n = n; in_s = s; in_e = e; in_w = w;
    in_last = last;
  endtask

  // One clock: record accepted input, score emitted output, end at posedge+1
  task automatic tick(output bit acc);
    exp_t e;
    #3;
    acc = in_valid && in_ready;
    if (acc) sb.push_back(model(in_c, in_n, in_s, in_e, in_w, in_last));
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pix", 32'(out_pix), 32'(e.pix));
        check("last", 32'(out_last), 32'(e.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick(acc);
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit acc;
    int k;
    int sent;
    logic [OUT_W-1:0] exp_pos, exp_neg;
`ifdef LAPLACE_SAT_EN
    exp_pos = 11'd255;
    exp_neg = 11'd0;
`else
    exp_pos = 11'h3FC;
    exp_neg = 11'h404;
`endif

    // Power-on reset
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pix", 32'(out_pix), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-stream with beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
      tick(acc);
    end
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_pix", 32'(out_pix), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    out_ready = 1'b1;
    tick(acc);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Flat image, latency of two cycles
    drive(1'b1, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 1'b0);
    tick(acc);
    check("flat_acc", 32'(acc), 32'd1);
    check("flat_lat1", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    tick(acc);
    check("flat_lat2", 32'(out_valid), 32'd1);
    check("flat_pix", 32'(out_pix), 32'd0);
    drain(10);

    // Extremes
    drive(1'b1, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick(acc);
    in_valid = 1'b0;
    tick(acc);
    check("ext_pos", 32'(out_pix), 32'(exp_pos));
    drain(10);
    drive(1'b1, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
    tick(acc);
    in_valid = 1'b0;
    tick(acc);
    check("ext_neg", 32'(out_pix), 32'(exp_neg));
    drain(10);

    // Back-pressure: 6 beats C=k, out_ready low for 5 cycles
    out_ready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(1'b1, 8'(k), 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      if (cyc >= 2) begin
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_pix", 32'(out_pix), 32'd0);
      end
      tick(acc);
      if (acc) k++;
    end
    check("bp_accepted", 32'(k), 32'd2);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && k < 6; cyc++) begin
      drive(1'b1, 8'(k), 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      tick(acc);
      if (acc) k++;
    end
    check("bp_sent", 32'(k), 32'd6);
    drain(10);

    // Streaming: 16 back-to-back beats
    n_out = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i * 3), 8'(i), 8'(2 * i), 8'(15 - i), 8'd7, (i == 15));
      tick(acc);
      check("stream_acc", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    tick(acc);
    tick(acc);
    check("stream_cnt", 32'(n_out), 32'd16);
    drain(10);

    // Random traffic
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc) sent++;
    end
    check("rand_sent", 32'(sent), 32'd1000);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
